// File: rtl/pipe_io_pkg.sv
// -----------------------------------------------------------------------------
// pipe_io_pkg
//   Shared definitions for the pipe-out capture path: the scheduler state
//   encoding and the default geometry of the capture memory.  The capture
//   memory and pipe readout blocks take their data width from here as well.
// -----------------------------------------------------------------------------
package pipe_io_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FULL    = 2'd2
   } sched_state_e;

   localparam int PIPE_DEPTH  = 1024;
   localparam int PIPE_ADDR_W = 10;
   localparam int PIPE_DATA_W = 32;

endpackage

// File: rtl/pipe_capture_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker.  The winner is the first set
//   request bit at or after ptr_i, wrapping modulo NUM_CH.
//
//   req_i       : per-channel request
//   ptr_i       : highest-priority channel this cycle
//   enable_i    : when low, no grant is issued
//   grant_o     : one-hot grant
//   grant_idx_o : index of the granted channel (0 when none)
//   any_grant_o : a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   input  logic              enable_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [CH_W-1:0]   grant_idx_o,
   output logic              any_grant_o
);

   always_comb begin
      logic [CH_W-1:0] cand;
      logic            found;
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = CH_W'((int'(ptr_i) + i) % NUM_CH);
         if (enable_i && !found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            grant_idx_o   = cand;
         end
      end
      any_grant_o = found;
   end

endmodule

// File: rtl/pipe_capture_sched.sv
// -----------------------------------------------------------------------------
// pipe_capture_sched
//   Shares the capture memory write port between NUM_CH sample sources.
//   arm starts a capture; requesting channels are served round-robin with a
//   programmable idle gap (decim) after each write.  When DEPTH samples have
//   been written capture_full rises and the block waits in FULL until the
//   readout side pulses readout_done.
//
//   Optional build macro: PIPE_SCHED_DROP_CNT_EN adds drop_cnt, a saturating
//   count of CAPTURE cycles in which some requester went unserved.
//
//   Ports
//     test_clk, reset1      : clock, async active-high reset
//     arm                   : start capture (level, sampled each cycle)
//     decim                 : idle cycles after each write
//     readout_done          : buffer fully read (already synchronised)
//     ch_valid / ch_ready   : per-channel request / one-hot grant.  A sample
//                             transfers in any cycle where ch_valid[i] and
//                             ch_ready[i] are both high; ch_ready never
//                             depends on anything latched from an earlier
//                             request, so dropping ch_valid withdraws it.
//     ch_data               : channel i sample at [i*DATA_W +: DATA_W]
//     mem_we/addr/wdata/tag : registered write port, one cycle after grant
//     capture_full          : buffer filled, readout may start
//     busy                  : state is CAPTURE or FULL
//     dbg_state             : current scheduler state
//     drop_cnt              : (optional) unserved-request cycles
// -----------------------------------------------------------------------------
module pipe_capture_sched
   import pipe_io_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = PIPE_DATA_W,
   parameter int DEPTH  = PIPE_DEPTH,
   parameter int ADDR_W = PIPE_ADDR_W,
   parameter int CH_W   = 2
) (
   input  logic                     test_clk,
   input  logic                     reset1,
   input  logic                     arm,
   input  logic [15:0]              decim,
   input  logic                     readout_done,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic [CH_W-1:0]          mem_tag,
   output logic                     capture_full,
   output logic                     busy,
   output logic [1:0]               dbg_state
`ifdef PIPE_SCHED_DROP_CNT_EN
   , output logic [15:0]            drop_cnt
`endif
);

   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

   sched_state_e    state_q, state_d;
   logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;   // one extra bit so DEPTH never aliases to 0
   logic [15:0]     gap_cnt_q, gap_cnt_d;
   logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
   logic            mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [CH_W-1:0] mem_tag_q, mem_tag_d;
   logic            full_q, full_d;
   logic            busy_q;
   logic            start_cap;            // entering CAPTURE this cycle

   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_idx;
   logic              any_grant;
   logic [DATA_W-1:0] win_data;

   rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
      .req_i       (ch_valid),
      .ptr_i       (rr_ptr_q),
      .enable_i    ((state_q == CAPTURE) && (gap_cnt_q == 16'd0)),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_grant_o (any_grant)
   );

   assign ch_ready = grant;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) win_data = ch_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_tag_d   = mem_tag_q;
      full_d      = full_q;
      start_cap   = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d   = CAPTURE;
               wr_cnt_d  = '0;
               gap_cnt_d = '0;
               start_cap = 1'b1;
            end
         end
         CAPTURE: begin
            if (any_grant) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = wr_cnt_q[ADDR_W-1:0];
               mem_wdata_d = win_data;
               mem_tag_d   = grant_idx;
               wr_cnt_d    = wr_cnt_q + 1'b1;
               gap_cnt_d   = decim;
               rr_ptr_d    = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
               // capture_full rises together with the last write strobe
               if (wr_cnt_q == LAST_IDX) begin
                  state_d = FULL;
                  full_d  = 1'b1;
               end
            end else if (gap_cnt_q != 16'd0) begin
               gap_cnt_d = gap_cnt_q - 16'd1;
            end
         end
         FULL: begin
            if (readout_done) begin
               full_d = 1'b0;
               if (arm) begin
                  state_d   = CAPTURE;
                  wr_cnt_d  = '0;
                  gap_cnt_d = '0;
                  start_cap = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge test_clk or posedge reset1) begin
      if (reset1) begin
         state_q     <= IDLE;
         wr_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         rr_ptr_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_tag_q   <= '0;
         full_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_tag_q   <= mem_tag_d;
         full_q      <= full_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_tag      = mem_tag_q;
   assign capture_full = full_q;
   assign busy         = busy_q;
   assign dbg_state    = state_q;

`ifdef PIPE_SCHED_DROP_CNT_EN
   logic [15:0] drop_cnt_q;
   // a cycle counts once if any requester is left without a grant
   wire drop_hit = (state_q == CAPTURE) && ((ch_valid & ~grant) != '0);

   always_ff @(posedge test_clk or posedge reset1) begin
      if (reset1) begin
         drop_cnt_q <= '0;
      end else if (start_cap) begin
         drop_cnt_q <= '0;
      end else if (drop_hit && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   // start_cap only feeds the optional drop counter
   logic unused_start;
   assign unused_start = start_cap;
`endif

endmodule

// File: tb/tb_pipe_capture_sched.sv
`timescale 1ns/1ps
module tb_pipe_capture_sched;

   logic         clk = 1'b0;
   logic         reset1 = 1'b1;
   logic         arm = 1'b0;
   logic [15:0]  decim = 16'd0;
   logic         readout_done = 1'b0;
   logic [3:0]   ch_valid = 4'b0000;
   logic [127:0] ch_data = '0;
   logic [3:0]   ch_ready;
   logic         mem_we;
   logic [9:0]   mem_addr;
   logic [31:0]  mem_wdata;
   logic [1:0]   mem_tag;
   logic         capture_full;
   logic         busy;
   logic [1:0]   dbg_state;
`ifdef PIPE_SCHED_DROP_CNT_EN
   logic [15:0]  drop_cnt;
`endif

   pipe_capture_sched dut (
      .test_clk     (clk),
      .reset1       (reset1),
      .arm          (arm),
      .decim        (decim),
      .readout_done (readout_done),
      .ch_valid     (ch_valid),
      .ch_data      (ch_data),
      .ch_ready     (ch_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_tag      (mem_tag),
      .capture_full (capture_full),
      .busy         (busy),
      .dbg_state    (dbg_state)
`ifdef PIPE_SCHED_DROP_CNT_EN
      , .drop_cnt   (drop_cnt)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int wr_seen  = 0;

   // ---------------- scoreboard with reference model ----------------
   // expected write: {addr[9:0], tag[1:0], data[31:0]}
   logic [43:0] exp_q[$];
   int          m_state = 0;
   logic [10:0] m_wr = '0;
   logic [15:0] m_gap = '0;
   int          m_ptr = 0;
   logic        m_full = 1'b0;
   logic        m_we_pend = 1'b0;
   logic [15:0] m_drop = '0;

   always begin : scoreboard
      logic [3:0]  mg;
      int          midx;
      int          c;
      logic [1:0]  mtag;
      logic [43:0] e;
      logic [10:0] old_wr;
      @(negedge clk);
      #2;
      if (reset1) begin
         m_state = 0; m_wr = '0; m_gap = '0; m_ptr = 0;
         m_full = 1'b0; m_we_pend = 1'b0; m_drop = '0;
         exp_q.delete();
      end else begin
         n_checks++;
         if (mem_we !== m_we_pend) begin
            n_errors++;
            $display("FAIL mem_we: got %b expected %b at %0t", mem_we, m_we_pend, $time);
         end
         if (mem_we === 1'b1) begin
            wr_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL write_unexpected: addr %0d with empty queue at %0t", mem_addr, $time);
            end else begin
               e = exp_q.pop_front();
               if ({mem_addr, mem_tag, mem_wdata} !== e) begin
                  n_errors++;
                  $display("FAIL write: got addr %0d tag %0d data %h expected addr %0d tag %0d data %h",
                           mem_addr, mem_tag, mem_wdata, e[43:34], e[33:32], e[31:0]);
               end
            end
         end
         n_checks++;
         if (capture_full !== m_full || busy !== (m_state != 0) || dbg_state !== 2'(m_state)) begin
            n_errors++;
            $display("FAIL status: got full %b busy %b state %0d expected full %b busy %b state %0d at %0t",
                     capture_full, busy, dbg_state, m_full, (m_state != 0), m_state, $time);
         end
`ifdef PIPE_SCHED_DROP_CNT_EN
         n_checks++;
         if (drop_cnt !== m_drop) begin
            n_errors++;
            $display("FAIL drop_cnt: got %0d expected %0d at %0t", drop_cnt, m_drop, $time);
         end
`endif
         mg = '0; midx = 0;
         if (m_state == 1 && m_gap == 16'd0) begin
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr + k) % 4;
               if (mg == 4'b0000 && ch_valid[c]) begin
                  mg[c] = 1'b1;
                  midx = c;
               end
            end
         end
         n_checks++;
         if (ch_ready !== mg) begin
            n_errors++;
            $display("FAIL ch_ready: got %b expected %b at %0t", ch_ready, mg, $time);
         end
         // advance the model across the coming rising edge
         m_we_pend = 1'b0;
         case (m_state)
            0: if (arm) begin m_state = 1; m_wr = '0; m_gap = '0; m_drop = '0; end
            1: begin
               if ((ch_valid & ~mg) != 4'b0000 && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
               if (mg != 4'b0000) begin
                  mtag = midx[1:0];
                  exp_q.push_back({m_wr[9:0], mtag, ch_data[midx*32 +: 32]});
                  m_we_pend = 1'b1;
                  old_wr = m_wr;
                  m_wr = m_wr + 11'd1;
                  m_gap = decim;
                  m_ptr = (midx + 1) % 4;
                  if (old_wr == 11'd1023) begin m_state = 2; m_full = 1'b1; end
               end else if (m_gap != 16'd0) begin
                  m_gap = m_gap - 16'd1;
               end
            end
            default: if (readout_done) begin
               m_full = 1'b0;
               if (arm) begin m_state = 1; m_wr = '0; m_gap = '0; m_drop = '0; end
               else m_state = 0;
            end
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      reset1 = 1'b1; arm = 1'b0; readout_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset1 = 1'b0;
   endtask

   task automatic arm_pulse();
      @(negedge clk); arm = 1'b1;
      @(negedge clk); arm = 1'b0;
   endtask

   task automatic readout_pulse();
      @(negedge clk); readout_done = 1'b1;
      @(negedge clk); readout_done = 1'b0;
   endtask

   task automatic wait_full(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #3;
         if (capture_full === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ch_valid = 4'b1111; arm = 1'b1;
      @(negedge clk);
      #3;
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, mem_tag, capture_full, busy, ch_ready, dbg_state} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got we %b addr %0d data %h tag %0d full %b busy %b rdy %b st %0d expected all 0",
                  mem_we, mem_addr, mem_wdata, mem_tag, capture_full, busy, ch_ready, dbg_state);
      end
      @(negedge clk);
      reset1 = 1'b0; arm = 1'b0; ch_valid = 4'b0000;
   endtask

   task automatic test_fill();
      bit ok;
      int k;
      ok = 1'b0;
      do_reset();
      decim = 16'd0; ch_valid = 4'b0001; wr_seen = 0;
      @(negedge clk); arm = 1'b1;
      @(negedge clk); arm = 1'b0; ch_data[31:0] = 32'h100; k = 1;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         ch_data[31:0] = 32'h100 + k; k++;
         #3;
         if (capture_full === 1'b1) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL fill_timeout: capture_full 0 expected 1"); end
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 10'd1023 || mem_wdata !== 32'h4FF) begin
         n_errors++;
         $display("FAIL fill_last: got we %b addr %0d data %h expected 1 1023 000004ff", mem_we, mem_addr, mem_wdata);
      end
      n_checks++;
      if (wr_seen !== 1024) begin n_errors++; $display("FAIL fill_count: got %0d expected 1024", wr_seen); end
      @(negedge clk);
      #3;
      n_checks++;
      if (dbg_state !== 2'd2 || ch_ready !== 4'b0000 || mem_we !== 1'b0) begin
         n_errors++;
         $display("FAIL fill_hold: got state %0d rdy %b we %b expected 2 0000 0", dbg_state, ch_ready, mem_we);
      end
      readout_pulse();
   endtask

   task automatic test_rotate();
      bit ok;
      int n;
      do_reset();
      decim = 16'd0; ch_valid = 4'b1111; n = 0;
      arm_pulse();
      for (int i = 0; i < 40 && n < 12; i++) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) ch_data[j*32 +: 32] = $urandom;
         #3;
         if (mem_we === 1'b1) begin
            n_checks++;
            if (mem_tag !== 2'(n % 4)) begin
               n_errors++;
               $display("FAIL rotate_tag: got %0d expected %0d", mem_tag, n % 4);
            end
            n_checks++;
            if ($countones(ch_ready) != 1) begin
               n_errors++;
               $display("FAIL rotate_onehot: got %b expected one-hot", ch_ready);
            end
            n++;
         end
      end
      n_checks++;
      if (n != 12) begin n_errors++; $display("FAIL rotate_count: got %0d expected 12", n); end
      wait_full(1200, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL rotate_full: capture_full 0 expected 1"); end
      readout_pulse();
   endtask

   task automatic test_decim();
      bit ok;
      int last, nint, cyc;
      do_reset();
      decim = 16'd3; ch_valid = 4'b0010; last = -1; nint = 0; cyc = 0;
      arm_pulse();
      for (int i = 0; i < 40 && nint < 6; i++) begin
         @(negedge clk);
         #3;
         cyc++;
         if (mem_we === 1'b1) begin
            if (last >= 0) begin
               n_checks++;
               if (cyc - last != 4) begin
                  n_errors++;
                  $display("FAIL decim_interval: got %0d expected 4", cyc - last);
               end
               nint++;
            end
            last = cyc;
         end
      end
      wait_full(5000, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL decim_full: capture_full 0 expected 1"); end
`ifdef PIPE_SCHED_DROP_CNT_EN
      n_checks++;
      if (drop_cnt !== 16'd3069) begin
         n_errors++;
         $display("FAIL decim_drop: got %0d expected 3069", drop_cnt);
      end
`endif
      decim = 16'd0;
   endtask

   task automatic test_readout();
      bit ok;
      readout_pulse();
      #3;
      n_checks++;
      if (capture_full !== 1'b0 || dbg_state !== 2'd0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL readout_idle: got full %b state %0d busy %b expected 0 0 0", capture_full, dbg_state, busy);
      end
      ch_valid = 4'b1111;
      arm_pulse();
      wait_full(1200, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL readout_refill: capture_full 0 expected 1"); end
      @(negedge clk); readout_done = 1'b1; arm = 1'b1;
      @(negedge clk); readout_done = 1'b0; arm = 1'b0;
      #3;
      n_checks++;
      if (dbg_state !== 2'd1 || capture_full !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL readout_rearm: got state %0d full %b busy %b expected 1 0 1", dbg_state, capture_full, busy);
      end
      @(negedge clk);
      #3;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 10'd0) begin
         n_errors++;
         $display("FAIL readout_addr0: got we %b addr %0d expected 1 0", mem_we, mem_addr);
      end
      wait_full(1200, ok);
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL readout_second: capture_full 0 expected 1"); end
      readout_pulse();
   endtask

   task automatic test_async_reset();
      bit ok;
      bit seen;
      ch_valid = 4'b0001; decim = 16'd0; wr_seen = 0; ok = 1'b0;
      arm_pulse();
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         #3;
         if (wr_seen >= 500) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin n_errors++; $display("FAIL areset_reach: got %0d writes expected 500", wr_seen); end
      reset1 = 1'b1;
      #1;
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, mem_tag, capture_full, busy, ch_ready, dbg_state} !== '0) begin
         n_errors++;
         $display("FAIL areset_outputs: got we %b addr %0d data %h tag %0d full %b busy %b rdy %b st %0d expected all 0",
                  mem_we, mem_addr, mem_wdata, mem_tag, capture_full, busy, ch_ready, dbg_state);
      end
      @(negedge clk);
      @(negedge clk);
      reset1 = 1'b0;
      wr_seen = 0; seen = 1'b0;
      arm_pulse();
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         #3;
         if (mem_we === 1'b1) begin
            seen = 1'b1;
            n_checks++;
            if (mem_addr !== 10'd0) begin
               n_errors++;
               $display("FAIL areset_restart: got addr %0d expected 0", mem_addr);
            end
         end
      end
      n_checks++;
      if (!seen) begin n_errors++; $display("FAIL areset_nowrite: got no write expected one"); end
      wait_full(1200, ok);
      n_checks++;
      if (!ok || wr_seen !== 1024) begin
         n_errors++;
         $display("FAIL areset_count: got %0d writes expected 1024", wr_seen);
      end
      readout_pulse();
   endtask

   task automatic test_ignore();
      bit ok;
      ok = 1'b0;
      ch_valid = 4'b1111; decim = 16'd0; wr_seen = 0;
      @(negedge clk); arm = 1'b1;
      for (int i = 0; i < 1300; i++) begin
         @(negedge clk);
         readout_done = (i % 100 == 50 && i < 1000);
         #3;
         if (capture_full === 1'b1) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok || wr_seen !== 1024) begin
         n_errors++;
         $display("FAIL ignore_count: got %0d writes expected 1024", wr_seen);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         readout_done = 1'b0;
         #3;
         n_checks++;
         if (dbg_state !== 2'd2 || capture_full !== 1'b1) begin
            n_errors++;
            $display("FAIL ignore_hold: got state %0d full %b expected 2 1", dbg_state, capture_full);
         end
      end
      n_checks++;
      if (wr_seen !== 1024) begin n_errors++; $display("FAIL ignore_extra: got %0d writes expected 1024", wr_seen); end
      @(negedge clk); arm = 1'b0;
      readout_pulse();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_rotate();
      test_decim();
      test_readout();
      test_async_reset();
      test_ignore();
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL leftover: got %0d pending writes expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
